lsu_axi: RTL and testbench
==========================

# lsu_axi

Parametrised load/store unit between EXU and WBU. Each accepted request becomes at most one AXI4-Lite read or write transaction. Sub-word data is lane-aligned for any bus width, and misaligned, unsupported-size and bus-error accesses are reported as faults instead of stalling. The EXU-to-WBU fields travel as an opaque sideband payload, so the same block serves any pipeline bundle.

## Interface
- XLEN, 32: register/result width (32 or 64).
- DATA_W, 32: AXI data width (32 or 64, ≥ XLEN).
- PAYLOAD_W, 128: width of the opaque passthrough bundle (pc, rd, write enables, ...).

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid from EXU.
- in_ready  out  1  LSU can accept a request.
- in_ren / in_wen  in  1  load / store; both low = no memory op; both high = load.
- in_size  in  2  0 byte, 1 half, 2 word, 3 double.
- in_signed  in  1  sign-extend load result.
- in_addr  in  32  effective address.
- in_wdata  in  XLEN  store data, LSB-justified.
- in_payload  in  PAYLOAD_W  passthrough bundle.
- out_valid  out  1  result valid to WBU.
- out_ready  in  1  WBU accepts.
- out_rdata  out  XLEN  extended load data; 0 for non-loads.
- out_payload  out  PAYLOAD_W  captured payload.
- out_fault  out  1  access faulted.
- out_cause  out  2  0 none, 1 misaligned, 2 bus error, 3 unsupported size.
- busy  out  1  state ≠ IDLE.
- AR channel: araddr out 32, arsize out 3, arvalid out 1, arready in 1.
- R channel: rdata in DATA_W, rresp in 2, rvalid in 1, rready out 1.
- AW channel: awaddr out 32, awsize out 3, awvalid out 1, awready in 1.
- W channel: wdata out DATA_W, wstrb out DATA_W/8, wvalid out 1, wready in 1.
- B channel: bresp in 2, bvalid in 1, bready out 1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- in_ready = (state == IDLE). Capture happens on in_valid && in_ready: addr, size, signed, wdata and payload are registered.
- Capture-time checks apply in priority order:
  - size 3 with XLEN == 32 → DONE, cause 3.
  - addr not aligned to 2^size → DONE, cause 1.
  - ren → RD_ADDR.
  - wen → WR_REQ.
  - otherwise → DONE, no fault.
  - Faulting requests issue no bus traffic.
- RD_ADDR: arvalid = 1 with araddr = addr and arsize = size. On arready → RD_DATA.
- RD_DATA: rready = 1. On rvalid, latch rdata → DONE.
  - Set cause 2 if rresp ≠ 0; out_rdata is still produced.
- Load extract: lane offset = addr[log2(DATA_W/8)-1:0]. Shift rdata right by offset×8, take 8 << size bits, then sign- or zero-extend to XLEN.
- WR_REQ: awvalid and wvalid are raised together.
  - Each drops independently after its own handshake; AW and W may complete in either order or in the same cycle.
  - → WR_RESP once both are done.
  - wdata = in_wdata shifted left by offset×8.
  - wstrb = ((1 << 2^size) − 1) << offset.
- WR_RESP: bready = 1. On bvalid → DONE; cause 2 if bresp ≠ 0.
- DONE: out_valid = 1, all out_* held stable. On out_ready → IDLE.

## Timing
- Reset values: state IDLE; out_valid, arvalid, awvalid, wvalid, rready, bready, out_fault all 0; out_cause 0; out_rdata 0; busy 0. Payload registers reset to 0.
- Reset mid-transaction aborts immediately with no completion; the bus slave is assumed to be reset with the core.
- Request accepted at edge N:
  - non-mem or faulting request: out_valid in cycle N+1.
  - zero-wait load (arready high, rvalid in the first RD_DATA cycle): out_valid in N+3.
  - zero-wait store: out_valid in N+3.
- out_valid-to-in_ready bubble: in_ready rises the cycle after the out_ready handshake, so there is no same-cycle re-accept.
- AXI valids never drop before their handshake. araddr, wdata and wstrb are stable while valid.
- rready and bready are asserted only in RD_DATA and WR_RESP. A response arriving in any other state is a protocol error and is not handled.

## Structure
- Package lsu_pkg: state enum, size enum (SZ_B/H/W/D), cause enum (C_NONE/C_MISALIGN/C_BUSERR/C_SIZE), alignment-check function.
- Sub-module lsu_lane_align (combinational, parametrised by XLEN and DATA_W): load extract/extend and store shift/strobe generation.
- lsu_axi holds the FSM, capture registers and handshake logic.

## Test plan
- Load byte, signed, addr 0x8000_0003, rdata 0x80xx_xxxx, DATA_W 32 → out_rdata 0xFFFF_FF80, cause 0; arsize 0.
- Store half, addr 0x8000_0002, in_wdata 0x1234 → wdata 0x1234_xxxx, wstrb 0b1100. With awready one cycle before wready, WR_RESP is entered only after both handshakes.
- Load word at 0x8000_0001 → out_valid the cycle after accept, cause 1, arvalid never asserted.
- Store word with bresp 2'b10 → out_fault 1, cause 2, FSM returns to IDLE after out_ready.
- Non-mem request with out_ready held low 5 cycles → out_valid and out_payload stable throughout, in_ready 0 until the cycle after release.
- rst asserted while in RD_DATA → next cycle: IDLE, all valids 0, in_ready 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the AXI4-Lite load/store unit.
//   state_t  - LSU controller states
//   size_t   - access size encoding (byte/half/word/double)
//   cause_t  - fault cause reported to writeback
//   is_misaligned() - natural-alignment check for an access size
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        C_NONE     = 2'd0,
        C_MISALIGN = 2'd1,
        C_BUSERR   = 2'd2,
        C_SIZE     = 2'd3
    } cause_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // An access of 2^size bytes must start on a 2^size byte boundary.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input size_t size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo[1:0];
            default: mis = |addr_lo[2:0];
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering between the register
// file view (LSB-justified, XLEN wide) and the AXI data bus (DATA_W wide).
//   addr_lo    - byte offset of the access within the bus word
//   size       - access size
//   is_signed  - sign-extend the load result
//   rdata      - raw bus read data
//   wdata_in   - LSB-justified store data
//   load_data  - extracted and extended load result
//   store_data - store data shifted onto its byte lanes
//   store_strb - byte strobes for the store
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [OFF_W-1:0]    addr_lo,
    input  size_t               size,
    input  logic                is_signed,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [XLEN-1:0]     wdata_in,
    output logic [XLEN-1:0]     load_data,
    output logic [DATA_W-1:0]   store_data,
    output logic [DATA_W/8-1:0] store_strb
);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0]      shifted;
    logic signed [XLEN-1:0] ext;
    logic [STRB_W-1:0]      strb_base;
    int                     nbits;
    int                     nbytes;

    // Load: move the addressed lanes to bit 0, then push the field to the top
    // of a signed word and shift it back down so the extension falls out of
    // the shift kind (arithmetic for signed, logical for unsigned).
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        nbits     = 8 << size;
        ext       = shifted[XLEN-1:0] << (XLEN - nbits);
        load_data = shifted[XLEN-1:0];
        if (nbits < XLEN) begin
            if (is_signed) begin
                load_data = ext >>> (XLEN - nbits);
            end else begin
                load_data = ext >> (XLEN - nbits);
            end
        end
    end

    // Store: data and strobes move up by the same lane offset.
    always_comb begin
        nbytes     = 1 << size;
        strb_base  = STRB_W'((1 << nbytes) - 1);
        store_data = DATA_W'(wdata_in) << {addr_lo, 3'b000};
        store_strb = strb_base << addr_lo;
    end

endmodule

// File: rtl/lsu_axi.sv
// lsu_axi: load/store unit between EXU and WBU. Each accepted request turns
// into at most one AXI4-Lite read or write; faults complete without bus
// traffic. The payload bundle is carried through untouched.
//   in_*        - request from EXU (valid/ready handshake)
//   out_*       - result to WBU (valid/ready handshake), held stable in DONE
//   busy        - controller not idle
//   ar/r/aw/w/b - AXI4-Lite master channels
module lsu_axi
    import lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_ren,
    input  logic                 in_wen,
    input  logic [1:0]           in_size,
    input  logic                 in_signed,
    input  logic [31:0]          in_addr,
    input  logic [XLEN-1:0]      in_wdata,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rdata,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_fault,
    output logic [1:0]           out_cause,
    output logic                 busy,
    output logic [31:0]          araddr,
    output logic [2:0]           arsize,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [DATA_W-1:0]    rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [31:0]          awaddr,
    output logic [2:0]           awsize,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [DATA_W-1:0]    wdata,
    output logic [DATA_W/8-1:0]  wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    state_t             state;
    logic [31:0]        addr_q;
    size_t              size_q;
    logic               signed_q;
    logic [XLEN-1:0]    wdata_q;
    logic [PAYLOAD_W-1:0] payload_q;

    size_t              in_size_e;
    logic               size_bad;
    logic               mis;
    logic               aw_fin;
    logic               w_fin;
    logic [XLEN-1:0]    load_data;
    logic [DATA_W-1:0]  store_data;
    logic [STRB_W-1:0]  store_strb;

    assign in_size_e = size_t'(in_size);
    assign size_bad  = (in_size_e == SZ_D) && (XLEN == 32);
    assign mis       = is_misaligned(in_addr[2:0], in_size_e);

    // A write channel counts as finished if it already handshook earlier or
    // is handshaking in this cycle.
    assign aw_fin = !awvalid || awready;
    assign w_fin  = !wvalid || wready;

    assign in_ready    = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign out_payload = payload_q;
    assign araddr      = addr_q;
    assign awaddr      = addr_q;
    assign arsize      = {1'b0, size_q};
    assign awsize      = {1'b0, size_q};
    assign wdata       = store_data;
    assign wstrb       = store_strb;

    lsu_lane_align #(
        .XLEN   (XLEN),
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .addr_lo    (addr_q[OFF_W-1:0]),
        .size       (size_q),
        .is_signed  (signed_q),
        .rdata      (rdata),
        .wdata_in   (wdata_q),
        .load_data  (load_data),
        .store_data (store_data),
        .store_strb (store_strb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= SZ_B;
            signed_q  <= 1'b0;
            wdata_q   <= '0;
            payload_q <= '0;
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_fault <= 1'b0;
            out_cause <= C_NONE;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        addr_q    <= in_addr;
                        size_q    <= in_size_e;
                        signed_q  <= in_signed;
                        wdata_q   <= in_wdata;
                        payload_q <= in_payload;
                        out_rdata <= '0;
                        out_fault <= 1'b0;
                        out_cause <= C_NONE;
                        // Checks in priority order; faults skip the bus.
                        if (size_bad) begin
                            out_fault <= 1'b1;
                            out_cause <= C_SIZE;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (mis) begin
                            out_fault <= 1'b1;
                            out_cause <= C_MISALIGN;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (in_ren) begin
                            arvalid <= 1'b1;
                            state   <= ST_RD_ADDR;
                        end else if (in_wen) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= ST_WR_REQ;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        out_rdata <= load_data;
                        if (rresp != RESP_OKAY) begin
                            out_fault <= 1'b1;
                            out_cause <= C_BUSERR;
                        end
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready <= 1'b1;
                        state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != RESP_OKAY) begin
                            out_fault <= 1'b1;
                            out_cause <= C_BUSERR;
                        end
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi.sv
// tb_lsu_axi: randomized bench for lsu_axi with an in-bench AXI4-Lite slave
// and a rule-level reference model of results, faults, lanes and latency.
module tb_lsu_axi;
    localparam int XLEN      = 32;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 128;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready, in_ren, in_wen, in_signed;
    logic [1:0]           in_size;
    logic [31:0]          in_addr;
    logic [XLEN-1:0]      in_wdata;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid, out_ready, out_fault, busy;
    logic [XLEN-1:0]      out_rdata;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [1:0]           out_cause;
    logic [31:0]          araddr, awaddr;
    logic [2:0]           arsize, awsize;
    logic                 arvalid, arready, rvalid, rready;
    logic                 awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]    rdata, wdata;
    logic [DATA_W/8-1:0]  wstrb;
    logic [1:0]           rresp, bresp;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;

    always #5 clk = ~clk;

    lsu_axi #(.XLEN(XLEN), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_payload(out_payload), .out_fault(out_fault), .out_cause(out_cause),
        .busy(busy),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_req(input logic ren, input logic wen, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [127:0] pl, input logic [31:0] rword,
                           input int ar_l, input int r_l, input int aw_l, input int w_l,
                           input int b_l, input logic err, input int hold);
        int nb, off, exp_lat, cyc, ar_c, r_c, aw_c, w_c, b_c;
        logic [1:0]  exp_cause;
        logic        exp_bus;
        logic [31:0] exp_rd, exp_wd;
        logic [3:0]  exp_strb;
        logic [63:0] v, m;
        bit got, saw_bus, aw_done, w_done, order_ok;

        // Reference model: result, fault, lanes and latency from the rules.
        nb  = 1 << size;
        off = int'(addr[1:0]);
        exp_bus = 1'b0; exp_rd = '0; exp_cause = 2'd0;
        if (size == 2'd3)                     exp_cause = 2'd3;
        else if ((int'(addr[2:0]) % nb) != 0) exp_cause = 2'd1;
        else if (ren || wen)                  exp_bus = 1'b1;
        m = (nb == 8) ? ~64'd0 : ((64'd1 << (8 * nb)) - 64'd1);
        v = (64'(rword) >> (8 * off)) & m;
        if (sgn && v[8 * nb - 1]) v = v | ~m;
        if (exp_bus && ren) begin
            exp_rd  = v[31:0];
            exp_lat = 3 + ar_l + r_l;
        end else if (exp_bus) begin
            exp_lat = 3 + ((aw_l > w_l) ? aw_l : w_l) + b_l;
        end else begin
            exp_lat = 1;
        end
        if (exp_bus && err) exp_cause = 2'd2;
        exp_wd   = 32'(64'(wd) << (8 * off));
        exp_strb = 4'((32'd1 << nb) - 32'd1) << off;

        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_size = size; in_signed = sgn;
        in_addr = addr; in_wdata = wd; in_payload = pl;
        @(negedge clk);
        check("in_ready_idle", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;

        cyc = 1; got = 0; saw_bus = 0; aw_done = 0; w_done = 0; order_ok = 1;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        while (!got && cyc <= 60) begin
            arready = arvalid && (ar_c >= ar_l); if (arvalid) ar_c++;
            rvalid  = rready  && (r_c  >= r_l);  if (rready)  r_c++;
            rdata   = rword;  rresp = err ? 2'b10 : 2'b00;
            awready = awvalid && (aw_c >= aw_l); if (awvalid) aw_c++;
            wready  = wvalid  && (w_c  >= w_l);  if (wvalid)  w_c++;
            bvalid  = bready  && (b_c  >= b_l);  if (bready)  b_c++;
            bresp   = err ? 2'b10 : 2'b00;
            @(negedge clk);
            if (bready && !(aw_done && w_done)) order_ok = 0;
            if (arvalid || awvalid || wvalid) saw_bus = 1;
            if (arvalid) begin
                check("araddr", 128'(araddr), 128'(addr));
                check("arsize", 128'(arsize), 128'({1'b0, size}));
            end
            if (awvalid) begin
                check("awaddr", 128'(awaddr), 128'(addr));
                check("awsize", 128'(awsize), 128'({1'b0, size}));
                if (awready) aw_done = 1;
            end
            if (wvalid) begin
                check("wdata", 128'(wdata), 128'(exp_wd));
                check("wstrb", 128'(wstrb), 128'(exp_strb));
                last_wdata = wdata; last_wstrb = wstrb;
                if (wready) w_done = 1;
            end
            if (out_valid) got = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        slave_idle();
        if (!got) begin
            check("timeout", 128'(0), 128'(1));
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            return;
        end

        last_rdata = out_rdata;
        check("latency", 128'(cyc), 128'(exp_lat));
        check("out_fault", 128'(out_fault), 128'(exp_cause != 2'd0));
        check("out_cause", 128'(out_cause), 128'(exp_cause));
        check("out_rdata", 128'(out_rdata), 128'(exp_rd));
        check("out_payload", out_payload, pl);
        check("in_ready_done", 128'(in_ready), 128'(0));
        check("bus_traffic", 128'(saw_bus), 128'(exp_bus));
        if (exp_bus && wen && !ren) check("b_after_aw_w", 128'(order_ok), 128'(1));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 128'(out_valid), 128'(1));
            check("hold_payload", out_payload, pl);
            check("hold_rdata", 128'(out_rdata), 128'(exp_rd));
            check("hold_cause", 128'(out_cause), 128'(exp_cause));
            check("hold_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready", 128'(in_ready), 128'(1));
        check("release_valid", 128'(out_valid), 128'(0));
        check("release_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] pl;
        logic [1:0]   sz;
        logic [31:0]  a;
        int           kind, nb, lo;

        rst = 1'b1; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_size = 2'd0;
        in_signed = 1'b0; in_addr = '0; in_wdata = '0; in_payload = '0; out_ready = 1'b0;
        slave_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valids", 128'({arvalid, awvalid, wvalid, rready, bready}), 128'(0));
        check("rst_fault", 128'({out_fault, out_cause}), 128'(0));
        check("rst_rdata", 128'(out_rdata), 128'(0));
        check("rst_payload", out_payload, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Signed byte load from the top lane, zero-wait.
        pl = {$urandom, $urandom, $urandom, $urandom};
        run_req(1, 0, 2'd0, 1, 32'h8000_0003, 32'h0, pl, 32'h80AA_BBCC, 0, 0, 0, 0, 0, 0, 0);
        check("tp_lb_rdata", 128'(last_rdata), 128'(32'hFFFF_FF80));

        // Half store to upper lanes; AW accepted a cycle before W.
        pl = {$urandom, $urandom, $urandom, $urandom};
        run_req(0, 1, 2'd1, 0, 32'h8000_0002, 32'h1234, pl, 32'h0, 0, 0, 0, 1, 0, 0, 1);
        check("tp_sh_wstrb", 128'(last_wstrb), 128'(4'b1100));
        check("tp_sh_wdata_hi", 128'(last_wdata[31:16]), 128'(16'h1234));

        // Misaligned word load, word store with error response, held non-mem.
        run_req(1, 0, 2'd2, 0, 32'h8000_0001, 32'h0, pl, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 2);
        run_req(0, 1, 2'd2, 0, 32'h8000_0008, 32'hDEAD_BEEF, pl, 32'h0, 0, 0, 0, 0, 0, 1, 1);
        pl = {$urandom, $urandom, $urandom, $urandom};
        run_req(0, 0, 2'd2, 0, 32'h0000_0000, 32'h0, pl, 32'h0, 0, 0, 0, 0, 0, 0, 5);

        // Reset while waiting for read data.
        in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_size = 2'd2; in_addr = 32'h8000_0010;
        @(posedge clk); #1;
        in_valid = 1'b0; in_ren = 1'b0;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        @(negedge clk);
        check("pre_rst_rready", 128'(rready), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_valids", 128'({arvalid, awvalid, wvalid, rready, bready, out_valid}), 128'(0));
        @(posedge clk); #1;

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            sz   = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
            nb   = 1 << sz;
            lo   = $urandom_range(0, 3);
            if ($urandom_range(0, 4) != 0) lo = lo & ~(nb - 1);
            a  = 32'h8000_0000 | ($urandom & 32'h0FFF_FFF0) | 32'(lo);
            pl = {$urandom, $urandom, $urandom, $urandom};
            run_req(kind < 4 || kind == 9, kind >= 4, sz, 1'($urandom_range(0, 1)), a,
                    $urandom, pl, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
